// File: rtl/regfile_pkg.sv
// Shared defaults and the address type for the scoreboarded register file.
// The REGFILE_BYPASS_EN macro is consumed by regfile_read_port.sv.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_COUNT  = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, x0 override and, when
// REGFILE_BYPASS_EN is defined, same-cycle write-through forwarding.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = REG_COUNT,
  parameter int AW    = REG_ADDR_W
) (
  input  logic [DEPTH*WIDTH-1:0] i_regs,
  input  logic [DEPTH-1:0]       i_busy,
  input  logic                   i_wr_ena,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic [AW-1:0]          i_rd_addr,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_rd_busy
);
  logic w_zero;

  assign w_zero = (i_rd_addr == '0);

`ifdef REGFILE_BYPASS_EN
  logic w_fwd;

  assign w_fwd = i_wr_ena && (i_wr_addr == i_rd_addr) && !w_zero;

  always_comb begin
    o_rd_data = i_regs[i_rd_addr*WIDTH +: WIDTH];
    o_rd_busy = i_busy[i_rd_addr];
    if (w_zero) begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
    end else if (w_fwd) begin
      o_rd_data = i_wr_data;
      o_rd_busy = 1'b0;
    end
  end
`else
  logic w_unused_bypass;

  assign w_unused_bypass = ^{i_wr_ena, i_wr_addr, i_wr_data};

  always_comb begin
    o_rd_data = i_regs[i_rd_addr*WIDTH +: WIDTH];
    o_rd_busy = i_busy[i_rd_addr];
    if (w_zero) begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
    end
  end
`endif
endmodule

// File: rtl/register_file_sb.sv
// Flop-based register file with a per-entry busy scoreboard, busy count and
// sticky double-reserve error. Optional forwarding via REGFILE_BYPASS_EN.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = XLEN,
  parameter int DEPTH    = REG_COUNT,
  parameter int NUM_READ = 2,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_ena,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WIDTH-1:0]          wr_data,
  input  logic                      rsv_ena,
  input  logic [AW-1:0]             rsv_addr,
  input  logic [NUM_READ*AW-1:0]    rd_addr,
  output logic [NUM_READ*WIDTH-1:0] rd_data,
  output logic [NUM_READ-1:0]       rd_busy,
  output logic [AW:0]               busy_count,
  output logic                      sb_error
);
  logic [WIDTH-1:0]       r_regs [DEPTH];
  logic [DEPTH-1:0]       r_busy;
  logic [AW:0]            r_busy_count;
  logic                   r_sb_error;
  logic [DEPTH-1:0]       w_busy_nxt;
  logic [DEPTH*WIDTH-1:0] w_regs_flat;
  logic                   w_wr_hit;
  logic                   w_rsv_hit;
  logic                   w_dbl_rsv;

  function automatic logic [AW:0] popcount(input logic [DEPTH-1:0] v);
    logic [AW:0] n;
    n = '0;
    for (int i = 0; i < DEPTH; i++) n = n + {{AW{1'b0}}, v[i]};
    return n;
  endfunction

  assign w_wr_hit  = wr_ena && (wr_addr != '0);
  assign w_rsv_hit = rsv_ena && (rsv_addr != '0);
  // A reserve landing on an entry whose producer retires this same cycle is legal.
  assign w_dbl_rsv = w_rsv_hit && r_busy[rsv_addr] && !(w_wr_hit && wr_addr == rsv_addr);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_hit) w_busy_nxt[wr_addr] = 1'b0;
    if (w_rsv_hit) w_busy_nxt[rsv_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_busy       <= '0;
      r_busy_count <= '0;
      r_sb_error   <= 1'b0;
    end else begin
      if (w_wr_hit) r_regs[wr_addr] <= wr_data;
      r_busy       <= w_busy_nxt;
      r_busy_count <= popcount(w_busy_nxt);
      if (w_dbl_rsv) r_sb_error <= 1'b1;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign w_regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

  for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
    regfile_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_port (
      .i_regs    (w_regs_flat),
      .i_busy    (r_busy),
      .i_wr_ena  (wr_ena),
      .i_wr_addr (wr_addr),
      .i_wr_data (wr_data),
      .i_rd_addr (rd_addr[p*AW +: AW]),
      .o_rd_data (rd_data[p*WIDTH +: WIDTH]),
      .o_rd_busy (rd_busy[p])
    );
  end

  assign busy_count = r_busy_count;
  assign sb_error   = r_sb_error;
endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench for register_file_sb (default 32x32, two read ports);
// expectations follow REGFILE_BYPASS_EN when it is defined.
module tb_register_file_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_ena;
  reg_addr_t   wr_addr;
  logic [31:0] wr_data;
  logic        rsv_ena;
  reg_addr_t   rsv_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_count;
  logic        sb_error;

  int n_tot = 0;
  int n_bad = 0;

  register_file_sb dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rsv_ena    (rsv_ena),
    .rsv_addr   (rsv_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .busy_count (busy_count),
    .sb_error   (sb_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    wr_ena  = 1'b0;
    rsv_ena = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  task automatic wr(input reg_addr_t a, input logic [31:0] d);
    wr_ena  = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rsv(input reg_addr_t a);
    rsv_ena  = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_ena = 1'b0; rsv_addr = '0; rd_addr = '0;
    tick();

    // 1: reset state on every address, both ports
    for (int a = 0; a < 32; a++) begin
      rd(reg_addr_t'(a), reg_addr_t'(31 - a));
      chk("rst_data", rd_data, 64'h0);
      chk("rst_busy", {62'h0, rd_busy}, 64'h0);
    end
    chk("rst_cnt", {58'h0, busy_count}, 64'h0);
    chk("rst_err", {63'h0, sb_error}, 64'h0);

    // 2: write then read next cycle; x0 stays zero
    wr(5, 32'hDEADBEEF);
    tick();
    rd(5, 5);
    chk("x5_p0", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
    chk("x5_p1", {32'h0, rd_data[63:32]}, 64'hDEADBEEF);
    wr(0, 32'h1234);
    tick();
    rd(0, 0);
    chk("x0_data", rd_data, 64'h0);

    // 3: reserve and retire x7
    rsv(7);
    tick();
    rd(7, 5);
    chk("x7_busy", {62'h0, rd_busy}, 64'h1);
    chk("x7_cnt", {58'h0, busy_count}, 64'd1);
    wr(7, 32'hA5);
    tick();
    rd(5, 7);
    chk("x7_free", {62'h0, rd_busy}, 64'h0);
    chk("x7_cnt0", {58'h0, busy_count}, 64'd0);
    chk("x7_data", {32'h0, rd_data[63:32]}, 64'hA5);

    // 4a: reserve with same-cycle retire of the same entry raises no error
    rsv(4);
    tick();
    wr(4, 32'h44); rsv(4);
    tick();
    rd(4, 0);
    chk("x4_err0", {63'h0, sb_error}, 64'h0);
    chk("x4_busy", {62'h0, rd_busy}, 64'h1);
    chk("x4_data", {32'h0, rd_data[31:0]}, 64'h44);
    wr(4, 32'h45);
    tick();

    // 4b: double reserve of x3 is sticky
    rsv(3);
    tick();
    chk("x3_err0", {63'h0, sb_error}, 64'h0);
    rsv(3);
    tick();
    chk("x3_err1", {63'h0, sb_error}, 64'h1);
    tick();
    chk("x3_stick", {63'h0, sb_error}, 64'h1);
    wr(3, 32'h77); rsv(3);
    tick();
    rd(3, 3);
    chk("x3_busy", {62'h0, rd_busy}, 64'h3);
    chk("x3_data", {32'h0, rd_data[31:0]}, 64'h77);
    chk("x3_err", {63'h0, sb_error}, 64'h1);
    chk("x3_cnt", {58'h0, busy_count}, 64'd1);

    // 4c: write and reserve to different entries both land
    wr(3, 32'h78); rsv(10);
    tick();
    rd(3, 10);
    chk("diff_busy", {62'h0, rd_busy}, 64'h2);
    chk("diff_data", {32'h0, rd_data[31:0]}, 64'h78);
    chk("diff_cnt", {58'h0, busy_count}, 64'd1);

    // 5: read of the entry being written this cycle
    wr(9, 32'h11);
    tick();
    rsv(9);
    tick();
    wr(9, 32'h55);
    rd(0, 9);
`ifdef REGFILE_BYPASS_EN
    chk("x9_same", {32'h0, rd_data[63:32]}, 64'h55);
    chk("x9_sbusy", {62'h0, rd_busy}, 64'h0);
`else
    chk("x9_same", {32'h0, rd_data[63:32]}, 64'h11);
    chk("x9_sbusy", {62'h0, rd_busy}, 64'h2);
`endif
    tick();
    rd(0, 9);
    chk("x9_next", {32'h0, rd_data[63:32]}, 64'h55);

    // 6: fill the scoreboard, then reset mid-sequence
    rst = 1'b1;
    tick();
    for (int a = 1; a < 32; a++) begin
      rsv(reg_addr_t'(a));
      tick();
    end
    chk("full_cnt", {58'h0, busy_count}, 64'd31);
    chk("full_err", {63'h0, sb_error}, 64'h0);
    rd(31, 1);
    chk("full_busy", {62'h0, rd_busy}, 64'h3);
    rst = 1'b1;
    tick();
    wr(12, 32'hCAFE);
    tick();
    for (int a = 1; a < 11; a++) begin
      rsv(reg_addr_t'(a));
      tick();
    end
    rsv(5);
    tick();
    chk("mid_err", {63'h0, sb_error}, 64'h1);
    chk("mid_cnt", {58'h0, busy_count}, 64'd10);
    rst = 1'b1; rsv(11); wr(13, 32'hBEEF);
    tick();
    rd(12, 5);
    chk("mrst_data", rd_data, 64'h0);
    chk("mrst_busy", {62'h0, rd_busy}, 64'h0);
    chk("mrst_cnt", {58'h0, busy_count}, 64'd0);
    chk("mrst_err", {63'h0, sb_error}, 64'h0);
    rd(13, 11);
    chk("mrst_d2", rd_data, 64'h0);
    chk("mrst_b2", {62'h0, rd_busy}, 64'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
